fp_adder_queue_driver: RTL and testbench

Queued, tagged, back-pressured driver for the FSM-based FP32 serial adder core, which speaks stb/ack. It is the parametrised successor to the single-shot start/busy/done adder driver. It accepts a stream of add or subtract requests through a valid/ready port and buffers them in a DEPTH-entry FIFO. It issues them one at a time to a single adder core and returns tagged results in order through a valid/ready response port with full backpressure. It sits between attention-score control logic and the adder core wherever several FP32 adds must be queued without software polling.

---
 rtl/fp_adder_queue_driver_if.sv | 13 +
 rtl/fp_adder_queue_driver.sv | 187 ++++++++++++++++++
 tb/tb_fp_adder_queue_driver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_adder_queue_driver_if.sv
// fp_adder_queue_driver_if: request/response handshake bundle for fp_adder_queue_driver
//   req_*  : valid/ready request carrying operands, subtract flag and tag
//   resp_* : valid/ready tagged FP32 result
//   master : requester side, slave : driver side
interface fp_adder_queue_driver_if #(parameter int TAG_W = 4);
  logic             req_valid, req_ready, req_sub, resp_valid, resp_ready;
  logic [31:0]      req_a, req_b, resp_z;
  logic [TAG_W-1:0] req_tag, resp_tag;
  modport master (output req_valid, req_a, req_b, req_sub, req_tag, resp_ready,
                  input  req_ready, resp_valid, resp_z, resp_tag);
  modport slave  (input  req_valid, req_a, req_b, req_sub, req_tag, resp_ready,
                  output req_ready, resp_valid, resp_z, resp_tag);
endinterface

// File: rtl/fp_adder_queue_driver.sv
// fp_adder_queue_driver: queued, tagged valid/ready front end around an FSM-based FP32 stb/ack adder core
//   clk, rst_n  : clock, synchronous active-low reset (the core sees ~rst_n)
//   bus (slave) : req_* requests in, resp_* tagged results out, both valid/ready
//   busy        : something queued, in flight or awaiting delivery
//   outstanding : requests accepted but not yet delivered
module fp_adder_queue_driver #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fp_adder_queue_driver_if.slave   bus,
  output logic                     busy,
  output logic [$clog2(DEPTH+2):0] outstanding
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(DEPTH + 2) + 1;
  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_t;
  typedef enum logic [2:0] {GET_A, GET_B, ALIGN, NORM, ROUND, PUT_Z} core_state_t;
  state_t           state_q, state_d;
  logic [63+TAG_W:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fifo_count_q, fifo_count_d;
  logic [OW-1:0]    out_q, out_d;
  logic [31:0]      a_q, a_d, b_q, b_d, resp_z_q, resp_z_d;
  logic [TAG_W-1:0] tag_q, tag_d, resp_tag_q, resp_tag_d;
  logic             resp_valid_q, resp_valid_d, push, pop, deliver;
  logic             a_stb, b_stb, a_ack, b_ack, z_stb, z_ack;
  core_state_t      cs_q, cs_d;
  logic [31:0]      ca_q, ca_d, cb_q, cb_d, cz_q, cz_d, big, sml;
  logic [27:0]      sum_q, sum_d, sum;
  logic [9:0]       e_q, e_d, e_r;
  logic             s_q, s_d, a_nan, b_nan, a_inf, b_inf, a_big;
  logic [7:0]       e_big, e_sml, d;
  logic [23:0]      m_big, m_sml;
  logic [26:0]      ext, al;
  logic [24:0]      mr;
  assign bus.req_ready   = rst_n && fifo_count_q < CW'(DEPTH);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_z      = resp_z_q;
  assign bus.resp_tag    = resp_tag_q;
  assign outstanding     = out_q;
  assign push    = bus.req_valid && bus.req_ready;
  assign pop     = state_q == IDLE && fifo_count_q != '0;
  assign deliver = resp_valid_q && bus.resp_ready;
  assign a_stb   = state_q == SEND_A;
  assign b_stb   = state_q == SEND_B;
  assign z_ack   = state_q == WAIT_Z && z_stb && (!resp_valid_q || bus.resp_ready);
  assign busy    = fifo_count_q != '0 || state_q != IDLE || resp_valid_q;
  // Subtraction is folded into a sign flip of B so the core only ever adds.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {bus.req_a, bus.req_b ^ {bus.req_sub, 31'd0}, bus.req_tag};
  always_comb begin
    {a_d, b_d, tag_d} = pop ? mem_q[rd_ptr_q] : {a_q, b_q, tag_q};
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
    out_d        = out_q + OW'(push) - OW'(deliver);
    resp_valid_d = z_ack || (resp_valid_q && !bus.resp_ready);
    resp_z_d     = z_ack ? cz_q : resp_z_q;
    resp_tag_d   = z_ack ? tag_q : resp_tag_q;
    case (state_q)
      IDLE:    state_d = pop ? SEND_A : IDLE;
      SEND_A:  state_d = a_ack ? SEND_B : SEND_A;
      SEND_B:  state_d = b_ack ? WAIT_Z : SEND_B;
      WAIT_Z:  state_d = z_ack ? IDLE : WAIT_Z;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      out_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      tag_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_z_q     <= '0;
      resp_tag_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      out_q        <= out_d;
      a_q          <= a_d;
      b_q          <= b_d;
      tag_q        <= tag_d;
      resp_valid_q <= resp_valid_d;
      resp_z_q     <= resp_z_d;
      resp_tag_q   <= resp_tag_d;
    end
  end
  // Adder core: fetch A, fetch B, align+add, normalise one bit per cycle, round-to-nearest-even, present Z.
  assign a_ack = cs_q == GET_A && a_stb;
  assign b_ack = cs_q == GET_B && b_stb;
  assign z_stb = cs_q == PUT_Z;
  always_comb begin
    a_nan = &ca_q[30:23] && |ca_q[22:0];
    b_nan = &cb_q[30:23] && |cb_q[22:0];
    a_inf = &ca_q[30:23] && ~|ca_q[22:0];
    b_inf = &cb_q[30:23] && ~|cb_q[22:0];
    a_big = ca_q[30:0] >= cb_q[30:0];
    big   = a_big ? ca_q : cb_q;
    sml   = a_big ? cb_q : ca_q;
    // Denormals use exponent 1 with no hidden bit.
    e_big = big[30:23] == 8'd0 ? 8'd1 : big[30:23];
    e_sml = sml[30:23] == 8'd0 ? 8'd1 : sml[30:23];
    m_big = {|big[30:23], big[22:0]};
    m_sml = {|sml[30:23], sml[22:0]};
    d     = e_big - e_sml;
    ext   = {m_sml, 3'b000};
    // Bits shifted out of the 3 guard positions collapse into the sticky LSB.
    al    = d >= 8'd27 ? {26'd0, |m_sml} : (ext >> d) | {26'd0, |(ext << (8'd27 - d))};
    sum   = big[31] == sml[31] ? {1'b0, m_big, 3'b000} + {1'b0, al} : {1'b0, m_big, 3'b000} - {1'b0, al};
    mr    = {1'b0, sum_q[26:3]} + {24'd0, sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3])};
    e_r   = e_q + {9'd0, mr[24]};
    cs_d  = cs_q;
    ca_d  = ca_q;
    cb_d  = cb_q;
    cz_d  = cz_q;
    sum_d = sum_q;
    e_d   = e_q;
    s_d   = s_q;
    case (cs_q)
      GET_A: if (a_stb) begin
        ca_d = a_q;
        cs_d = GET_B;
      end
      GET_B: if (b_stb) begin
        cb_d = b_q;
        cs_d = ALIGN;
      end
      ALIGN: begin
        cs_d = PUT_Z;
        if (a_nan || b_nan || (a_inf && b_inf && ca_q[31] != cb_q[31])) cz_d = 32'h7FC0_0000;
        else if (a_inf) cz_d = ca_q;
        else if (b_inf) cz_d = cb_q;
        else begin
          sum_d = sum;
          e_d   = {2'd0, e_big};
          s_d   = sum == 28'd0 && ca_q[31] != cb_q[31] ? 1'b0 : big[31];
          cs_d  = NORM;
        end
      end
      NORM:
        if (sum_q[27]) begin
          sum_d = {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
          e_d   = e_q + 10'd1;
          cs_d  = ROUND;
        end else if (!sum_q[26] && e_q > 10'd1) begin
          sum_d = {sum_q[26:0], 1'b0};
          e_d   = e_q - 10'd1;
        end else cs_d = ROUND;
      ROUND: begin
        cs_d = PUT_Z;
        cz_d = e_r >= 10'd255 ? {s_q, 8'hFF, 23'd0}
             : {s_q, ((mr[24] | mr[23]) ? e_r[7:0] : 8'd0), (mr[24] ? 23'd0 : mr[22:0])};
      end
      PUT_Z:   cs_d = z_ack ? GET_A : PUT_Z;
      default: cs_d = GET_A;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q  <= GET_A;
      ca_q  <= '0;
      cb_q  <= '0;
      cz_q  <= '0;
      sum_q <= '0;
      e_q   <= '0;
      s_q   <= 1'b0;
    end else begin
      cs_q  <= cs_d;
      ca_q  <= ca_d;
      cb_q  <= cb_d;
      cz_q  <= cz_d;
      sum_q <= sum_d;
      e_q   <= e_d;
      s_q   <= s_d;
    end
  end
endmodule

// File: tb/tb_fp_adder_queue_driver.sv
// tb_fp_adder_queue_driver: directed self-checking bench for fp_adder_queue_driver
module tb_fp_adder_queue_driver;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  logic [$clog2(DEPTH+2):0] outstanding;
  int n_cmp = 0, n_err = 0, n_push = 0, stb_both = 0, full_seen = 0, ready_bad = 0;
  logic [31:0] rz_q[$];
  logic [TAG_W-1:0] rt_q[$];
  fp_adder_queue_driver_if #(.TAG_W(TAG_W)) bus();
  fp_adder_queue_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .outstanding(outstanding));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (rst_n && bus.resp_valid && bus.resp_ready) begin
      rz_q.push_back(bus.resp_z);
      rt_q.push_back(bus.resp_tag);
    end
  always @(negedge clk)
    if (rst_n) begin
      if (dut.a_stb && dut.b_stb) stb_both++;
      if (int'(dut.fifo_count_q) == DEPTH && !bus.req_ready) full_seen++;
      if (bus.req_ready != (int'(dut.fifo_count_q) < DEPTH)) ready_bad++;
    end

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [TAG_W-1:0] tag);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_sub = sub;
    bus.req_tag = tag;
    while (!bus.req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      n_cmp++;
      n_err++;
      $display("FAIL push_timeout: req_ready stayed 0, need 1");
    end else n_push++;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while (rz_q.size() < n && t < 600) begin
      @(negedge clk);
      t++;
    end
    if (t >= 600) begin
      n_cmp++;
      n_err++;
      $display("FAIL resp_timeout: got %0d responses, need %0d", rz_q.size(), n);
    end
  endtask

  task automatic clear_q();
    rz_q.delete();
    rt_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_sub = 1'b0;
    bus.req_tag = '0;
    bus.resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready: got %b need 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b need 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 32'h0) begin n_err++; $display("FAIL rst_resp_z: got %h need 0", bus.resp_z); end
    n_cmp++; if (bus.resp_tag !== 4'h0) begin n_err++; $display("FAIL rst_resp_tag: got %h need 0", bus.resp_tag); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL rst_outstanding: got %0d need 0", outstanding); end
    n_cmp++; if ({dut.a_stb, dut.b_stb} !== 2'b00) begin n_err++; $display("FAIL rst_stb: got %b need 00", {dut.a_stb, dut.b_stb}); end
    rst_n = 1'b1;
    n_push = 0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rel_req_ready: got %b need 1", bus.req_ready); end
  endtask

  task automatic test_single_add();
    bus.resp_ready = 1'b1;
    clear_q();
    push(32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd5);
    wait_resp(1);
    repeat (3) @(negedge clk);
    n_cmp++; if (rz_q.size() != 1) begin n_err++; $display("FAIL add_count: got %0d need 1", rz_q.size()); end
    n_cmp++; if ((rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF) !== 32'h4040_0000) begin n_err++; $display("FAIL add_z: got %h need 40400000", rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rt_q.size() > 0 ? rt_q[0] : 4'hF) !== 4'd5) begin n_err++; $display("FAIL add_tag: got %h need 5", rt_q.size() > 0 ? rt_q[0] : 4'hF); end
    n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL add_outstanding: got %0d need 0", outstanding); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL add_busy: got %b need 0", busy); end
  endtask

  task automatic test_subtract();
    bus.resp_ready = 1'b1;
    clear_q();
    push(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd6);
    push(32'h3F80_0000, 32'h3F80_0000, 1'b1, 4'd7);
    wait_resp(2);
    n_cmp++; if ((rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF) !== 32'h4000_0000) begin n_err++; $display("FAIL sub_z0: got %h need 40000000", rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rt_q.size() > 0 ? rt_q[0] : 4'hF) !== 4'd6) begin n_err++; $display("FAIL sub_tag0: got %h need 6", rt_q.size() > 0 ? rt_q[0] : 4'hF); end
    n_cmp++; if ((rz_q.size() > 1 ? rz_q[1] : 32'hDEAD_BEEF) !== 32'h0000_0000) begin n_err++; $display("FAIL sub_z1: got %h need 00000000", rz_q.size() > 1 ? rz_q[1] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rt_q.size() > 1 ? rt_q[1] : 4'hF) !== 4'd7) begin n_err++; $display("FAIL sub_tag1: got %h need 7", rt_q.size() > 1 ? rt_q[1] : 4'hF); end
  endtask

  task automatic test_fill_wrap();
    bus.resp_ready = 1'b1;
    clear_q();
    full_seen = 0;
    ready_bad = 0;
    for (int i = 0; i < DEPTH + 3; i++) push(32'(i), 32'h1, 1'b0, TAG_W'(i));
    wait_resp(DEPTH + 3);
    repeat (3) @(negedge clk);
    n_cmp++; if (full_seen == 0) begin n_err++; $display("FAIL fill_full_seen: got %0d cycles, need >0", full_seen); end
    n_cmp++; if (ready_bad != 0) begin n_err++; $display("FAIL fill_ready_rule: got %0d bad cycles, need 0", ready_bad); end
    n_cmp++; if (rz_q.size() != DEPTH + 3) begin n_err++; $display("FAIL fill_count: got %0d need %0d", rz_q.size(), DEPTH + 3); end
    for (int i = 0; i < DEPTH + 3; i++) begin
      n_cmp++; if ((rz_q.size() > i ? rz_q[i] : 32'hDEAD_BEEF) !== 32'(i + 1)) begin n_err++; $display("FAIL fill_z%0d: got %h need %h", i, rz_q.size() > i ? rz_q[i] : 32'hDEAD_BEEF, 32'(i + 1)); end
      n_cmp++; if ((rt_q.size() > i ? rt_q[i] : 4'hF) !== TAG_W'(i)) begin n_err++; $display("FAIL fill_tag%0d: got %h need %h", i, rt_q.size() > i ? rt_q[i] : 4'hF, TAG_W'(i)); end
    end
    n_cmp++; if (int'(dut.wr_ptr_q) != n_push % DEPTH) begin n_err++; $display("FAIL fill_wr_ptr: got %0d need %0d", dut.wr_ptr_q, n_push % DEPTH); end
    n_cmp++; if (int'(dut.rd_ptr_q) != n_push % DEPTH) begin n_err++; $display("FAIL fill_rd_ptr: got %0d need %0d", dut.rd_ptr_q, n_push % DEPTH); end
    n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL fill_outstanding: got %0d need 0", outstanding); end
  endtask

  task automatic test_backpressure();
    int t = 0;
    int unstable = 0;
    bus.resp_ready = 1'b0;
    clear_q();
    push(32'h10, 32'h2, 1'b0, 4'd8);
    push(32'h11, 32'h2, 1'b0, 4'd9);
    push(32'h12, 32'h2, 1'b0, 4'd10);
    while (!(bus.resp_valid && dut.z_stb) && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (t >= 300) begin n_err++; $display("FAIL bp_stall_timeout: stall state not reached, got resp_valid=%b z_stb=%b", bus.resp_valid, dut.z_stb); end
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_z !== 32'h12 || bus.resp_tag !== 4'd8 || dut.z_ack !== 1'b0 || bus.resp_valid !== 1'b1) unstable++;
    end
    n_cmp++; if (unstable != 0) begin n_err++; $display("FAIL bp_hold: got %0d unstable cycles, need 0", unstable); end
    n_cmp++; if (bus.resp_z !== 32'h12) begin n_err++; $display("FAIL bp_first_z: got %h need 00000012", bus.resp_z); end
    n_cmp++; if (dut.z_ack !== 1'b0) begin n_err++; $display("FAIL bp_z_ack: got %b need 0", dut.z_ack); end
    n_cmp++; if (rz_q.size() != 0) begin n_err++; $display("FAIL bp_no_early: got %0d responses need 0", rz_q.size()); end
    for (int k = 0; k < 3; k++) begin
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      repeat (30) @(negedge clk);
      n_cmp++; if (rz_q.size() != k + 1) begin n_err++; $display("FAIL bp_count%0d: got %0d need %0d", k, rz_q.size(), k + 1); end
      n_cmp++; if ((rz_q.size() > k ? rz_q[k] : 32'hDEAD_BEEF) !== 32'(32'h12 + k)) begin n_err++; $display("FAIL bp_z%0d: got %h need %h", k, rz_q.size() > k ? rz_q[k] : 32'hDEAD_BEEF, 32'(32'h12 + k)); end
      n_cmp++; if ((rt_q.size() > k ? rt_q[k] : 4'hF) !== TAG_W'(8 + k)) begin n_err++; $display("FAIL bp_tag%0d: got %h need %h", k, rt_q.size() > k ? rt_q[k] : 4'hF, TAG_W'(8 + k)); end
    end
    n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL bp_outstanding: got %0d need 0", outstanding); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_busy: got %b need 0", busy); end
    n_cmp++; if (stb_both != 0) begin n_err++; $display("FAIL stb_exclusive: got %0d overlap cycles need 0", stb_both); end
  endtask

  task automatic test_specials();
    logic nan_ok;
    bus.resp_ready = 1'b1;
    clear_q();
    push(32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd1);
    push(32'h0000_0001, 32'h0000_0001, 1'b0, 4'd2);
    push(32'h7F80_0000, 32'h3F80_0000, 1'b0, 4'd3);
    wait_resp(3);
    nan_ok = rz_q.size() > 0 && rz_q[0][30:23] == 8'hFF && rz_q[0][22:0] != 23'd0;
    n_cmp++; if (nan_ok !== 1'b1) begin n_err++; $display("FAIL sp_nan: got %h need exp=FF frac!=0", rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rz_q.size() > 1 ? rz_q[1] : 32'hDEAD_BEEF) !== 32'h0000_0002) begin n_err++; $display("FAIL sp_denorm: got %h need 00000002", rz_q.size() > 1 ? rz_q[1] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rz_q.size() > 2 ? rz_q[2] : 32'hDEAD_BEEF) !== 32'h7F80_0000) begin n_err++; $display("FAIL sp_inf: got %h need 7f800000", rz_q.size() > 2 ? rz_q[2] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rt_q.size() > 2 ? rt_q[2] : 4'hF) !== 4'd3) begin n_err++; $display("FAIL sp_tag: got %h need 3", rt_q.size() > 2 ? rt_q[2] : 4'hF); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    bus.resp_ready = 1'b0;
    clear_q();
    for (int i = 1; i <= 4; i++) push(32'h3F80_0000, 32'h4000_0000, 1'b0, TAG_W'(i));
    while (!(bus.resp_valid && dut.z_stb && int'(dut.fifo_count_q) == 2) && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (t >= 300) begin n_err++; $display("FAIL mid_setup_timeout: got fifo_count=%0d need 2 with engine waiting", dut.fifo_count_q); end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL mid_resp_valid: got %b need 0", bus.resp_valid); end
    n_cmp++; if (bus.resp_z !== 32'h0) begin n_err++; $display("FAIL mid_resp_z: got %h need 0", bus.resp_z); end
    n_cmp++; if (bus.resp_tag !== 4'h0) begin n_err++; $display("FAIL mid_resp_tag: got %h need 0", bus.resp_tag); end
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL mid_req_ready: got %b need 0", bus.req_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b need 0", busy); end
    n_cmp++; if (outstanding !== '0) begin n_err++; $display("FAIL mid_outstanding: got %0d need 0", outstanding); end
    n_cmp++; if (dut.z_stb !== 1'b0) begin n_err++; $display("FAIL mid_core_z_stb: got %b need 0", dut.z_stb); end
    rst_n = 1'b1;
    n_push = 0;
    bus.resp_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (rz_q.size() != 0) begin n_err++; $display("FAIL mid_stale: got %0d responses need 0", rz_q.size()); end
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after: got %b need 1", bus.req_ready); end
    push(32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd9);
    wait_resp(1);
    n_cmp++; if ((rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF) !== 32'h4000_0000) begin n_err++; $display("FAIL mid_new_z: got %h need 40000000", rz_q.size() > 0 ? rz_q[0] : 32'hDEAD_BEEF); end
    n_cmp++; if ((rt_q.size() > 0 ? rt_q[0] : 4'hF) !== 4'd9) begin n_err++; $display("FAIL mid_new_tag: got %h need 9", rt_q.size() > 0 ? rt_q[0] : 4'hF); end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_subtract();
    test_fill_wrap();
    test_backpressure();
    test_specials();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
